bus_share_arbiter: RTL and testbench

- Shares one 32-bit address/data path between two requesters: port 0 (instruction fetch) and port 1 (load/store).
- Drives the Control input of the team's 32-bit two-input selector so that exactly one source reaches the shared resource.
- Holds a grant across multi-cycle transfers until the resource signals Done.
- Round-robin fairness between the two ports, plus a hold-time limit so neither port starves the other.

---
 rtl/bus_share_pkg.sv | 18 +
 rtl/bus_share_arbiter_mux.sv | 15 +
 rtl/bus_share_arbiter.sv | 123 ++++++++++++
 tb/tb_bus_share_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_share_pkg.sv
// Shared definitions for the two-port bus share arbiter: FSM encoding and defaults.
package bus_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_MAX_HOLD   = 16;

  // Ownership state for a port index (0 -> OWN0, 1 -> OWN1).
  function automatic state_t own_state(input logic port);
    return port ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/bus_share_arbiter_mux.sv
// Two-input selector: Control=1 passes OneInput, otherwise ZeroInput.
module bus_share_arbiter_mux #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  Control,
  input  logic [DATA_WIDTH-1:0] ZeroInput,
  input  logic [DATA_WIDTH-1:0] OneInput,
  output logic [DATA_WIDTH-1:0] DataOutput
);

  always_comb begin
    DataOutput = Control ? OneInput : ZeroInput;
  end

endmodule

// File: rtl/bus_share_arbiter.sv
// Round-robin arbiter sharing one data path between fetch (port 0) and load/store (port 1),
// holding grants across multi-cycle transfers with a hold-time limit against starvation.
module bus_share_arbiter
  import bus_share_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned MAX_HOLD   = DEFAULT_MAX_HOLD,
  parameter int unsigned HOLD_W     = $clog2(MAX_HOLD)
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Req0,
  input  logic                  Req1,
  input  logic [DATA_WIDTH-1:0] Data0,
  input  logic [DATA_WIDTH-1:0] Data1,
  input  logic                  Done,
  output logic                  Gnt0,
  output logic                  Gnt1,
  output logic                  Sel,
  output logic [DATA_WIDTH-1:0] BusData,
  output logic                  BusValid
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_next;
  logic              r_last_owner;
  logic              w_last_next;
  logic              r_sel;
  logic              w_sel_next;

  logic              w_cur;
  logic              w_mine;
  logic              w_other;
  logic              w_release;
  logic              w_enter;
  logic              w_port;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_hold       <= '0;
      r_last_owner <= 1'b1;
      r_sel        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_hold       <= w_hold_next;
      r_last_owner <= w_last_next;
      r_sel        <= w_sel_next;
    end
  end

  // Every grant (fresh, handover or restart) funnels through w_enter so the
  // hold counter, LastOwner and Sel are updated in exactly one place.
  always_comb begin
    w_state_next = r_state;
    w_hold_next  = '0;
    w_last_next  = r_last_owner;
    w_sel_next   = r_sel;
    w_enter      = 1'b0;
    w_port       = 1'b0;
    w_cur        = (r_state == ST_OWN1);
    w_mine       = w_cur ? Req1 : Req0;
    w_other      = w_cur ? Req0 : Req1;
    w_release    = Done | ~w_mine | ((r_hold == HOLD_LAST) & w_other);

    case (r_state)
      ST_IDLE: begin
        if (Req0 | Req1) begin
          w_enter = 1'b1;
          w_port  = (Req0 & Req1) ? ~r_last_owner : Req1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (w_release) begin
          if (w_other) begin
            w_enter = 1'b1;
            w_port  = ~w_cur;
          end else if (w_mine) begin
            w_enter = 1'b1;
            w_port  = w_cur;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else if (r_hold != HOLD_LAST) begin
          w_hold_next = r_hold + HOLD_W'(1);
        end else begin
          w_hold_next = r_hold;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (w_enter) begin
      w_state_next = own_state(w_port);
      w_hold_next  = '0;
      w_last_next  = w_port;
      w_sel_next   = w_port;
    end
  end

  always_comb begin
    Gnt0     = (r_state == ST_OWN0);
    Gnt1     = (r_state == ST_OWN1);
    BusValid = (r_state == ST_OWN0) | (r_state == ST_OWN1);
    Sel      = r_sel;
  end

  bus_share_arbiter_mux #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sel (
    .Control    (Sel),
    .ZeroInput  (Data0),
    .OneInput   (Data1),
    .DataOutput (BusData)
  );

endmodule

// File: tb/tb_bus_share_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural owner model.
module tb_bus_share_arbiter;

  localparam int MH = 4;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Req0, Req1, Done;
  logic [31:0] Data0, Data1, BusData;
  logic        Gnt0, Gnt1, Sel, BusValid;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: owner (-1 none), grant cycles held so far, last owner, selector value.
  int   m_owner;
  int   m_held;
  int   m_last;
  logic m_sel;

  int   cnt;

  always #5 CLK = ~CLK;

  bus_share_arbiter #(
    .DATA_WIDTH(32),
    .MAX_HOLD  (MH)
  ) dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .Req0    (Req0),
    .Req1    (Req1),
    .Data0   (Data0),
    .Data1   (Data1),
    .Done    (Done),
    .Gnt0    (Gnt0),
    .Gnt1    (Gnt1),
    .Sel     (Sel),
    .BusData (BusData),
    .BusValid(BusValid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 1;
    m_sel   = 1'b0;
  endtask

  task automatic model_grant(input int n);
    m_owner = n;
    m_held  = 1;
    m_last  = n;
    m_sel   = (n == 1);
  endtask

  task automatic model_edge();
    bit mine, other, rel;
    if (m_owner < 0) begin
      if (Req0 && Req1) model_grant(m_last == 1 ? 0 : 1);
      else if (Req0)    model_grant(0);
      else if (Req1)    model_grant(1);
    end else begin
      mine  = (m_owner == 0) ? Req0 : Req1;
      other = (m_owner == 0) ? Req1 : Req0;
      rel   = Done || !mine || (m_held >= MH && other);
      if (rel) begin
        if (other)     model_grant(1 - m_owner);
        else if (mine) model_grant(m_owner);
        else           m_owner = -1;
      end else if (m_held < MH) begin
        m_held = m_held + 1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".gnt0"},  Gnt0,     m_owner == 0);
    check_eq({tag, ".gnt1"},  Gnt1,     m_owner == 1);
    check_eq({tag, ".valid"}, BusValid, m_owner >= 0);
    check_eq({tag, ".sel"},   Sel,      m_sel);
    check_eq({tag, ".data"},  BusData,  m_sel ? Data1 : Data0);
    check_eq({tag, ".excl"},  Gnt0 & Gnt1, 0);
  endtask

  task automatic step(input string tag);
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_outputs(tag);
  endtask

  // Called at a negedge: reset lands mid-phase, outputs are checked before any edge.
  task automatic async_reset(input string tag);
    #2 Reset = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    check_eq({tag, ".sel0"}, Sel, 0);
    @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    Req0  = 1'b0;
    Req1  = 1'b0;
    Done  = 1'b0;
    Data0 = '0;
    Data1 = 32'h1234_5678;
    model_reset();
    #1;
    check_outputs("por");
    @(negedge CLK);
    Reset = 1'b0;

    // Single port 0 transfer, Done on third grant cycle.
    Data0 = 32'hDEAD_BEEF;
    Data1 = $urandom;
    Req0  = 1'b1;
    cnt   = 0;
    for (int i = 0; i < 6; i++) begin
      step("beef");
      if (Gnt0) begin
        cnt++;
        check_eq("beef.bus", BusData, 32'hDEAD_BEEF);
      end
      if (i == 2) begin
        Done = 1'b1;
        Req0 = 1'b0;
      end else begin
        Done = 1'b0;
      end
    end
    check_eq("beef.len", cnt, 3);

    // Both requesting with Done every cycle: strict alternation from port 0.
    async_reset("alt.rst");
    Req0 = 1'b1;
    Req1 = 1'b1;
    Done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("alt");
      check_eq("alt.selseq", Sel, i % 2);
      check_eq("alt.busy", BusValid, 1);
    end
    Req0 = 1'b0;
    Req1 = 1'b0;
    Done = 1'b0;
    step("alt.end");

    // Forced release after MAX_HOLD cycles while port 0 waits.
    async_reset("frc.rst");
    Req1 = 1'b1;
    step("frc");
    check_eq("frc.g1_first", Gnt1, 1);
    Req0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("frc");
      check_eq("frc.g1_hold", Gnt1, 1);
    end
    step("frc");
    check_eq("frc.g0_after", Gnt0, 1);
    Req0 = 1'b0;
    Req1 = 1'b0;
    step("frc.end");

    // Abandon in OWN1: back to IDLE with Sel left at 1.
    async_reset("abn.rst");
    Req1 = 1'b1;
    step("abn");
    Req1 = 1'b0;
    step("abn");
    check_eq("abn.sel_kept", Sel, 1);
    check_eq("abn.idle", BusValid, 0);

    // Reset while OWN1 with both requesting: first grant after reset is port 0.
    async_reset("own1.rst0");
    Req1 = 1'b1;
    step("own1");
    Req0 = 1'b1;
    async_reset("own1.rst");
    step("own1.after");
    check_eq("own1.first_g0", Gnt0, 1);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      Data0 = $urandom;
      Data1 = $urandom;
      if ($urandom_range(0, 3) == 0) Req0 = ~Req0;
      if ($urandom_range(0, 3) == 0) Req1 = ~Req1;
      Done = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) async_reset("rnd.rst");
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
